lc_mmu: RTL

Parametrised successor to the LC256 glue/MMU for the next board revision. Decodes the 65xx bus into RAM, ROM, cartridge and I/O selects, and adds a write-only bank/ROM-control register. Adds per-channel I/O wait states and a clocked DMA hand-over state machine. Sits between the CPU/DMA bus and the memory/peripheral chip selects; all state is inside this block.

---
 rtl/lc_mmu_pkg.sv | 23 ++
 rtl/lc_waitgen.sv | 32 +++
 rtl/lc_mmu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lc_mmu_pkg.sv
`default_nettype none
//==== lc_mmu_pkg : shared FSM type and decode constants for lc_mmu -- rev 1.0 ====
package lc_mmu_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STOP = 2'd1,
        ST_DMA  = 2'd2,
        ST_REL  = 2'd3
    } mmu_state_e;

    localparam logic [5:0] IOPAGE    = 6'b110111;
    localparam logic [2:0] CTL_SLOT  = 3'd7;
    localparam int         ROMH_BIT  = 7;
    localparam int         ROML_BIT  = 6;
    localparam logic [7:0] CTL_RESET = 8'hC0;

    function automatic logic is_io_page(input logic [5:0] a_hi);
        return a_hi == IOPAGE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc_waitgen.sv
`default_nettype none
//==== lc_waitgen : per-access wait-state counter with busy extension -- rev 1.0 ====
module lc_waitgen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic [2:0] wait_max,
    input  logic       busy_n,
    output logic       done,
    output logic       rdy
);

    logic [2:0] cnt;
    logic       reached;

    assign reached = (cnt >= wait_max);
    assign rdy     = !active || (reached && busy_n);
    assign done    = active && rdy;

    // Counter holds at wait_max while busy keeps the access open.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 3'd0;
        end else if (!active || rdy) begin
            cnt <= 3'd0;
        end else if (!reached) begin
            cnt <= cnt + 3'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lc_mmu.sv
`default_nettype none
//==== lc_mmu : 65xx bus decode/MMU with bank register, I/O waits and DMA hand-over -- rev 1.0 ====
module lc_mmu
    import lc_mmu_pkg::*;
#(
    parameter  int               NBANK   = 4,
    parameter  int               NCS     = 4,
    parameter  logic [NCS*3-1:0] WAIT_CS = '0,
    localparam int               BW      = $clog2(NBANK)
) (
    input  logic            PHI2,
    input  logic            _RESET,
    input  logic [15:7]     A,
    input  logic [7:0]      D,
    input  logic            R_W,
    input  logic            SYNC,
    input  logic            _DMA,
    input  logic            _EXTL,
    input  logic            _EXTH,
    input  logic            _BUSY,
    output logic            RDY,
    output logic            BA,
    output logic            _KB0,
    output logic            _RAM0,
    output logic            _RAM1,
    output logic [BW-1:0]   RBANK,
    output logic            _ROM,
    output logic            _CART,
    output logic            _IO,
    output logic [NCS-1:0]  _CSR,
    output logic [NCS-1:0]  _CSW
);

    mmu_state_e    state, state_nxt;
    logic          rom_h, rom_l;
    logic [BW-1:0] bank;
    logic [2:0]    slot, wait_sel;
    logic          run, io_hit, ctl_hit, ch_hit;
    logic          wg_done, wg_rdy, strobe_en;
    logic          kb0_hit, roml_win, romh_win, cart_sel, rom_sel, ram_sel;
    logic          unused_d;

    assign run     = (state == ST_RUN);
    assign slot    = A[9:7];
    assign io_hit  = is_io_page(A[15:10]);
    assign ctl_hit = io_hit && (slot == CTL_SLOT);
    assign unused_d = ^D;

    always_comb begin
        ch_hit   = 1'b0;
        wait_sel = 3'd0;
        for (int i = 0; i < NCS; i++) begin
            if (slot == 3'(i)) begin
                ch_hit   = io_hit;
                wait_sel = WAIT_CS[i*3 +: 3];
            end
        end
    end

    lc_waitgen u_waitgen (
        .clk      (PHI2),
        .rst_n    (_RESET),
        .active   (run && ch_hit),
        .wait_max (wait_sel),
        .busy_n   (_BUSY),
        .done     (wg_done),
        .rdy      (wg_rdy)
    );

    always_ff @(negedge PHI2 or negedge _RESET) begin
        if (!_RESET) begin
            rom_h <= CTL_RESET[ROMH_BIT];
            rom_l <= CTL_RESET[ROML_BIT];
            bank  <= CTL_RESET[BW-1:0];
        end else if (run && ctl_hit && !R_W) begin
            rom_h <= D[ROMH_BIT];
            rom_l <= D[ROML_BIT];
            bank  <= D[BW-1:0];
        end
    end

    always_ff @(negedge PHI2 or negedge _RESET) begin
        if (!_RESET) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Cartridge windows take priority over the ROM they overlay; writes fall through to RAM.
    assign kb0_hit  = (A[15:10] == 6'd0);
    assign roml_win = (A[15:13] == 3'b101);
    assign romh_win = (A[15:13] == 3'b111);
    assign cart_sel = (!_EXTL && (A[15:13] == 3'b100)) || (!_EXTH && roml_win);
    assign rom_sel  = R_W && !cart_sel && ((romh_win && rom_h) || (roml_win && rom_l));
    assign ram_sel  = !(kb0_hit || io_hit || cart_sel || rom_sel);

    always_comb begin
        state_nxt = state;
        _KB0      = 1'b1;
        _RAM0     = 1'b1;
        _RAM1     = 1'b1;
        _ROM      = 1'b1;
        _CART     = 1'b1;
        _IO       = 1'b1;
        case (state)
            ST_RUN: begin
                if (!_DMA && SYNC && wg_rdy) state_nxt = ST_STOP;
                _KB0  = !kb0_hit;
                _ROM  = !rom_sel;
                _CART = !cart_sel;
                _IO   = !io_hit;
                _RAM0 = !(PHI2 && ram_sel && !A[15]);
                _RAM1 = !(PHI2 && ram_sel && A[15]);
            end
            ST_STOP: state_nxt = _DMA ? ST_RUN : ST_DMA;
            ST_DMA: begin
                if (_DMA) state_nxt = ST_REL;
                // The DMA master owns timing, so RAM follows the address alone.
                _RAM0 = A[15];
                _RAM1 = !A[15];
            end
            ST_REL:  state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    assign RDY       = !_RESET || (run && wg_rdy);
    assign BA        = (state == ST_DMA);
    assign RBANK     = (A[15:14] == 2'b01) ? bank : BW'(NBANK - 1);
    assign strobe_en = _RESET && PHI2 && wg_done;

    generate
        for (genvar i = 0; i < NCS; i++) begin : g_cs
            assign _CSR[i] = !(strobe_en && (slot == 3'(i)) && R_W);
            assign _CSW[i] = !(strobe_en && (slot == 3'(i)) && !R_W);
        end
    endgenerate

endmodule
`default_nettype wire
